// File: rtl/game_pkg.sv
// game_pkg: shared state encoding, default parameters and speed helper for game_ctrl.
package game_pkg;
   typedef enum logic [2:0] {MENU, PLAY, HIT, PAUSE, WIN, LOSE} state_t;
   localparam int DEF_LIVES     = 3;
   localparam int DEF_LEVELS    = 4;
   localparam int DEF_LEVEL_LEN = 240;
   localparam int DEF_HIT_TICKS = 24;
   localparam int DEF_SCORE_W   = 16;
   function automatic logic [3:0] speed_of(input int unsigned lvl);
      return (lvl >= 32'd14) ? 4'd15 : 4'(lvl + 32'd1);
   endfunction
endpackage

// File: rtl/btn_edge.sv
// btn_edge: rising-edge pulse from an already synchronised button.
module btn_edge (
   input  logic clk,
   input  logic reset_n,
   input  logic btn,
   output logic rise
);
   logic prev_q;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) prev_q <= 1'b0;
      else          prev_q <= btn;
   assign rise = btn & ~prev_q;
endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: multi-level, multi-life game sequencer with score and hit window.
// Define GAME_PAUSE_EN to build the PAUSE state and the pause button edge detector.
module game_ctrl
   import game_pkg::*;
#(
   parameter int LIVES     = DEF_LIVES,
   parameter int LEVELS    = DEF_LEVELS,
   parameter int LEVEL_LEN = DEF_LEVEL_LEN,
   parameter int HIT_TICKS = DEF_HIT_TICKS,
   parameter int SCORE_W   = DEF_SCORE_W,
   localparam int LIVES_W  = $clog2(LIVES + 1),
   localparam int LEVEL_W  = (LEVELS > 1) ? $clog2(LEVELS) : 1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               tick,
   input  logic               jump_btn,
   input  logic               pause_btn,
   input  logic               collision,
   output state_t             state,
   output logic               menu_screen,
   output logic               play_active,
   output logic               win_screen,
   output logic               lose_screen,
   output logic               invuln,
   output logic [SCORE_W-1:0] score,
   output logic [LIVES_W-1:0] lives,
   output logic [LEVEL_W-1:0] level,
   output logic [3:0]         speed
);
   localparam int LCNT_W = (LEVEL_LEN > 1) ? $clog2(LEVEL_LEN) : 1;
   localparam int HCNT_W = (HIT_TICKS > 1) ? $clog2(HIT_TICKS) : 1;

   state_t             state_q, state_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [LIVES_W-1:0] lives_q, lives_d;
   logic [LEVEL_W-1:0] level_q, level_d;
   logic [LCNT_W-1:0]  lcnt_q, lcnt_d;
   logic [HCNT_W-1:0]  hit_q, hit_d;
   logic               jump_rise, pause_rise, lvl_done;

   btn_edge u_jump (.clk(clk), .reset_n(reset_n), .btn(jump_btn), .rise(jump_rise));
`ifdef GAME_PAUSE_EN
   btn_edge u_pause (.clk(clk), .reset_n(reset_n), .btn(pause_btn), .rise(pause_rise));
`else
   logic unused_pause;
   assign unused_pause = pause_btn;
   assign pause_rise   = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      score_d  = score_q;
      lives_d  = lives_q;
      level_d  = level_q;
      lcnt_d   = lcnt_q;
      hit_d    = hit_q;
      lvl_done = lcnt_q == LCNT_W'(LEVEL_LEN - 1);
      case (state_q)
         MENU: begin
            score_d = '0;
            lives_d = LIVES_W'(LIVES);
            level_d = '0;
            lcnt_d  = '0;
            if (jump_rise) state_d = PLAY;
         end
         PLAY, HIT: begin
            // collision outranks pause and level completion; HIT ignores it
            if (state_q == PLAY && collision) begin
               if (lives_q == LIVES_W'(1)) begin
                  lives_d = '0;
                  state_d = LOSE;
               end else begin
                  lives_d = lives_q - LIVES_W'(1);
                  hit_d   = '0;
                  state_d = HIT;
               end
            end else if (state_q == PLAY && pause_rise) begin
               state_d = PAUSE;
            end else if (tick) begin
               score_d = &score_q ? score_q : score_q + SCORE_W'(1);
               lcnt_d  = lvl_done ? '0 : lcnt_q + LCNT_W'(1);
               if (state_q == HIT) begin
                  hit_d = hit_q + HCNT_W'(1);
                  if (hit_q == HCNT_W'(HIT_TICKS - 1)) state_d = PLAY;
               end
               if (lvl_done) begin
                  if (level_q == LEVEL_W'(LEVELS - 1)) state_d = WIN;
                  else                                 level_d = level_q + LEVEL_W'(1);
               end
            end
         end
         PAUSE:     if (pause_rise) state_d = PLAY;
         WIN, LOSE: if (jump_rise) state_d = MENU;
         default:   state_d = MENU;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state_q <= MENU;
         score_q <= '0;
         lives_q <= LIVES_W'(LIVES);
         level_q <= '0;
         lcnt_q  <= '0;
         hit_q   <= '0;
      end else begin
         state_q <= state_d;
         score_q <= score_d;
         lives_q <= lives_d;
         level_q <= level_d;
         lcnt_q  <= lcnt_d;
         hit_q   <= hit_d;
      end

   assign state       = state_q;
   assign menu_screen = state_q == MENU;
   assign play_active = state_q == PLAY;
   assign win_screen  = state_q == WIN;
   assign lose_screen = state_q == LOSE;
   assign invuln      = state_q == HIT;
   assign score       = score_q;
   assign lives       = lives_q;
   assign level       = level_q;
   assign speed       = speed_of(32'(level_q));
endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed scoreboard bench for game_ctrl (small levels, short hit window).
module tb_game_ctrl;
   import game_pkg::*;
`ifdef GAME_PAUSE_EN
   localparam bit PE = 1'b1;
`else
   localparam bit PE = 1'b0;
`endif
   logic clk = 1'b0, reset_n = 1'b0, tick = 1'b0, jump_btn = 1'b0, pause_btn = 1'b0, collision = 1'b0;
   state_t state;
   logic menu_screen, play_active, win_screen, lose_screen, invuln;
   logic [15:0] score;
   logic [1:0]  lives;
   logic [0:0]  level;
   logic [3:0]  speed;

   game_ctrl #(.LIVES(3), .LEVELS(2), .LEVEL_LEN(4), .HIT_TICKS(3), .SCORE_W(16)) dut (
      .clk(clk), .reset_n(reset_n), .tick(tick), .jump_btn(jump_btn), .pause_btn(pause_btn),
      .collision(collision), .state(state), .menu_screen(menu_screen), .play_active(play_active),
      .win_screen(win_screen), .lose_screen(lose_screen), .invuln(invuln), .score(score),
      .lives(lives), .level(level), .speed(speed)
   );

   always #5 clk = ~clk;

   typedef logic [30:0] snap_t;
   typedef struct {string tag; snap_t v;} exp_t;
   exp_t sb[$];
   int errors = 0, checks = 0;

   function automatic snap_t dut_snap();
      return {state, lives, level, score, speed, menu_screen, play_active, win_screen, lose_screen, invuln};
   endfunction

   task automatic push_exp(input string tag, input state_t st, input int lv, input int lvl, input int sc);
      exp_t e;
      e.tag = tag;
      e.v = {st, 2'(lv), 1'(lvl), 16'(sc), 4'(lvl + 1), st == MENU, st == PLAY, st == WIN, st == LOSE, st == HIT};
      sb.push_back(e);
   endtask

   task automatic chk();
      exp_t e;
      snap_t obs;
      e = sb.pop_front();
      obs = dut_snap();
      checks++;
      assert (obs === e.v) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.v);
      end
   endtask

   task automatic step(input bit t, input bit j, input bit p, input bit c);
      tick = t; jump_btn = j; pause_btn = p; collision = c;
      @(posedge clk);
      @(negedge clk);
      tick = 0; jump_btn = 0; pause_btn = 0; collision = 0;
   endtask

   task automatic stepc(input bit t, input bit j, input bit p, input bit c, input string tag,
                        input state_t st, input int lv, input int lvl, input int sc);
      push_exp(tag, st, lv, lvl, sc);
      step(t, j, p, c);
      chk();
   endtask

   initial begin
      @(negedge clk);
      push_exp("reset", MENU, 3, 0, 0);
      chk();
      @(negedge clk);
      reset_n = 1'b1;
      stepc(0, 1, 0, 0, "start", PLAY, 3, 0, 0);
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      stepc(1, 0, 0, 0, "tick3", PLAY, 3, 0, 3);
      stepc(1, 0, 0, 0, "level1", PLAY, 3, 1, 4);
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
      stepc(1, 0, 0, 0, "win", WIN, 3, 1, 8);
      stepc(1, 0, 0, 1, "win_frozen", WIN, 3, 1, 8);
      stepc(0, 1, 0, 0, "to_menu", MENU, 3, 1, 8);
      stepc(0, 0, 0, 0, "menu_load", MENU, 3, 0, 0);
      stepc(0, 1, 0, 0, "start2", PLAY, 3, 0, 0);
      stepc(0, 0, 0, 1, "hit1", HIT, 2, 0, 0);
      stepc(1, 0, 0, 1, "hit_ignore", HIT, 2, 0, 1);
      stepc(1, 0, 0, 0, "hit_tick2", HIT, 2, 0, 2);
      stepc(1, 0, 0, 0, "hit_exit", PLAY, 2, 0, 3);
      stepc(1, 0, 0, 1, "coll_beats_level", HIT, 1, 0, 3);
      stepc(1, 0, 0, 0, "level_in_hit", HIT, 1, 1, 4);
      stepc(1, 0, 0, 0, "hit2_tick2", HIT, 1, 1, 5);
      stepc(1, 0, 0, 0, "hit2_exit", PLAY, 1, 1, 6);
      stepc(1, 0, 0, 0, "pre_final", PLAY, 1, 1, 7);
      stepc(1, 0, 0, 1, "lose_final", LOSE, 0, 1, 7);
      stepc(1, 0, 0, 0, "lose_frozen", LOSE, 0, 1, 7);
      stepc(0, 1, 0, 0, "lose_menu", MENU, 0, 1, 7);
      stepc(0, 0, 0, 0, "menu_reload", MENU, 3, 0, 0);
      stepc(0, 1, 0, 0, "start3", PLAY, 3, 0, 0);
      stepc(0, 0, 1, 0, "pause_in", PE ? PAUSE : PLAY, 3, 0, 0);
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      stepc(1, 0, 0, 0, "pause_ticks", PE ? PAUSE : PLAY, 3, 0, PE ? 0 : 3);
      stepc(0, 0, 1, 0, "pause_out", PLAY, 3, 0, PE ? 0 : 3);
      stepc(0, 0, 1, 1, "pause_vs_coll", HIT, 2, 0, PE ? 0 : 3);
      #2 reset_n = 1'b0;
      #1 push_exp("async_reset", MENU, 3, 0, 0);
      chk();
      @(negedge clk);
      reset_n = 1'b1;
      jump_btn = 1'b1;
      @(posedge clk);
      @(negedge clk);
      push_exp("held_jump", PLAY, 3, 0, 0);
      chk();
      collision = 1'b1;
      @(posedge clk);
      @(negedge clk);
      collision = 1'b0;
      jump_btn = 1'b0;
      push_exp("coll_jump_held", HIT, 2, 0, 0);
      chk();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/game_ctrl.md
# game_ctrl

Parametrised second-generation game controller for the obstacle game. It replaces the single-shot menu/win/lose sequencer with a multi-level, multi-life state machine. It also adds score tracking, a post-hit invulnerability window and an optional pause. It sits between the player inputs, the collision detector and the VGA renderer, and is clocked by the 50 MHz system clock. Game progress advances only on the one-cycle `tick` enable produced by the slow-clock divider.

## Interface
Parameters:
- LIVES, 3: lives at game start; legal range 1–15.
- LEVELS, 4: number of levels to clear for a win; must be ≥1.
- LEVEL_LEN, 240: ticks of survival needed to clear one level.
- HIT_TICKS, 24: length of the invulnerability window after a hit, in ticks.
- SCORE_W, 16: score counter width.

Ports:
- clk  in  1  system clock (50 MHz).
- reset_n  in  1  asynchronous, active-low reset.
- tick  in  1  game-frame enable, one-cycle pulse.
- jump_btn  in  1  player button, active-high, already synchronised.
- pause_btn  in  1  pause button, active-high, already synchronised.
- collision  in  1  player/obstacle overlap, level signal.
- state  out  3  current state, encoded as game_pkg::state_t.
- menu_screen, play_active, win_screen, lose_screen  out  1 each  one-hot state decodes.
- invuln  out  1  high while in HIT.
- score  out  SCORE_W  ticks survived.
- lives  out  LIVES_W  lives remaining; LIVES_W = $clog2(LIVES+1).
- level  out  LEVEL_W  current level, 0-based; LEVEL_W = max(1, $clog2(LEVELS)).
- speed  out  4  scroll speed for the renderer; equals level+1, saturates at 15.

## Operation
- Reset values: state = MENU, score = 0, lives = LIVES, level = 0, internal level_cnt = 0, hit_cnt = 0, edge-detector history = 0.
- jump_rise and pause_rise are rising-edge pulses from the btn_edge instances (input high AND previous sample low).
- MENU:
  - On jump_rise: go to PLAY.
  - Load score = 0, lives = LIVES, level = 0, level_cnt = 0.
- PLAY, priority highest first:
  1. collision.
     - If lives == 1: lives = 0, go to LOSE.
     - Otherwise: lives decrements, hit_cnt = 0, go to HIT.
  2. pause_rise (only when GAME_PAUSE_EN is defined): go to PAUSE.
  3. tick:
     - score increments, saturating at all-ones.
     - level_cnt increments.
     - When level_cnt == LEVEL_LEN-1: level_cnt = 0, and
       - if level == LEVELS-1, go to WIN (level is held);
       - otherwise level increments.
- HIT:
  - collision is ignored.
  - Each tick increments hit_cnt and score, and advances level_cnt with the same rules as PLAY, including the transition to WIN.
  - When hit_cnt == HIT_TICKS-1 on a tick, go to PLAY.
- PAUSE:
  - tick and collision are ignored; no counter changes.
  - pause_rise returns to PLAY.
- WIN and LOSE:
  - score, lives and level are frozen.
  - jump_rise goes to MENU.
- Simultaneous events:
  - collision and level completion on the same cycle: the collision wins, and the level does not advance.
  - pause_rise together with collision: the collision wins.
- jump_btn is ignored in PLAY, HIT and PAUSE. Jump physics are handled elsewhere.

## Timing
- All outputs are registered or decoded directly from registers. No input reaches an output combinationally.
- An input event at clock edge n produces its state and counter update visible after edge n. Latency is 1 clock.
- A button held high produces exactly one rise. A new rise requires at least one cycle low.
- reset_n assertion forces reset values immediately and asynchronously, including mid-game and mid-HIT. Release is synchronous to clk.
- speed updates in the same cycle as level.

## Configuration
- GAME_PAUSE_EN defined:
  - The PAUSE state and the pause_btn edge detector are built.
  - State behaviour is as described under Operation.
- GAME_PAUSE_EN undefined:
  - pause_btn is ignored and the PAUSE state is unreachable; its encoding stays reserved.
  - The second btn_edge instance is not instantiated.
  - All other behaviour is identical.

## Structure
- game_pkg holds:
  - typedef enum logic [2:0] state_t {MENU, PLAY, HIT, PAUSE, WIN, LOSE};
  - the default parameter constants;
  - a helper function for speed saturation.
- One sub-module, btn_edge:
  - contains a single history register with reset_n;
  - produces a rise pulse;
  - is instantiated once for jump, and once for pause under GAME_PAUSE_EN.
- Counter-width localparams are derived inside game_ctrl.

## Test plan
- Reset, then jump_rise → PLAY with lives = 3, score = 0, level = 0, menu_screen low and play_active high one cycle later.
- LEVEL_LEN = 4, LEVELS = 2, no collisions → level = 1 after 4 ticks; WIN after 8 ticks with score = 8.
- Collision in PLAY with lives = 3 → HIT, lives = 2. Further collisions during the next HIT_TICKS ticks are ignored. Return to PLAY after tick HIT_TICKS.
- Three separated collisions → LOSE with lives = 0. jump_rise → MENU. The next jump_rise reloads lives = 3.
- Collision on the same cycle as the final level-completing tick → HIT (or LOSE if on the last life), and level is unchanged.
- With GAME_PAUSE_EN: pause_rise → PAUSE, 10 ticks leave score unchanged, pause_rise → PLAY. Without GAME_PAUSE_EN the same stimulus leaves state = PLAY and score = 10.
